// File: rtl/vote_controller.sv
// Four-candidate voting controller: officer arming, single-vote capture with
// multi-press rejection, timed acknowledge, and registered result readout.
module vote_controller #(
  parameter int CNT_W      = 8,
  parameter int ACK_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [3:0]       cand_press,
  input  logic             mode,
  input  logic [1:0]       result_sel,
  output logic             ready,
  output logic             vote_ack,
  output logic             reject,
  output logic [CNT_W-1:0] result,
  output logic [CNT_W+1:0] total_votes
);

  // state  | meaning
  // IDLE   | waiting for officer arm or result request
  // ARMED  | one vote enabled, waiting for a candidate press
  // ACK    | vote accepted, vote_ack held for ACK_CYCLES clocks
  // RESULT | displaying the count selected by result_sel
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [7:0] ACK_LOAD = 8'(ACK_CYCLES - 1);

  logic [1:0]       state;
  logic [7:0]       ack_cnt;
  logic [CNT_W-1:0] cnt [4];
  logic             one_hot;
  logic             multi;
  logic [1:0]       cand_idx;

  always_comb begin
    one_hot  = (cand_press != 4'd0) && ((cand_press & (cand_press - 4'd1)) == 4'd0);
    multi    = (cand_press != 4'd0) && !one_hot;
    cand_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cand_press[i]) cand_idx = 2'(i);
    end
  end

  assign ready    = (state == S_ARMED);
  assign vote_ack = (state == S_ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ack_cnt     <= '0;
      reject      <= 1'b0;
      result      <= '0;
      total_votes <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      reject <= 1'b0;
      result <= (state == S_RESULT) ? cnt[result_sel] : '0;
      case (state)
        S_IDLE: begin
          if (mode)     state <= S_RESULT;
          else if (arm) state <= S_ARMED;
        end
        S_ARMED: begin
          // mode cancels the arming even when a press lands on the same cycle
          if (mode) begin
            state <= S_RESULT;
          end else if (multi) begin
            reject <= 1'b1;
          end else if (one_hot) begin
            if (cnt[cand_idx] != '1) cnt[cand_idx] <= cnt[cand_idx] + CNT_W'(1);
            if (total_votes != '1)  total_votes <= total_votes + (CNT_W+2)'(1);
            ack_cnt <= ACK_LOAD;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          if (ack_cnt == 8'd0) state <= S_IDLE;
          else                 ack_cnt <= ack_cnt - 8'd1;
        end
        S_RESULT: begin
          if (!mode) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_controller.sv
// Directed bench for vote_controller: vector table plus multi-cycle sequences.
module tb_vote_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm;
  logic [3:0] cand_press;
  logic       mode;
  logic [1:0] result_sel;
  logic       ready;
  logic       vote_ack;
  logic       reject;
  logic [7:0] result;
  logic [9:0] total_votes;

  int checks = 0;
  int errors = 0;

  vote_controller #(.CNT_W(8), .ACK_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .arm(arm), .cand_press(cand_press),
    .mode(mode), .result_sel(result_sel), .ready(ready),
    .vote_ack(vote_ack), .reject(reject), .result(result),
    .total_votes(total_votes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       arm;
    logic [3:0] cand;
    logic       mode;
    logic [1:0] sel;
    int         extra;
    logic       e_ready;
    logic       e_ack;
    logic       e_rej;
    logic [7:0] e_res;
    logic [9:0] e_tot;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // inputs change just after a negedge; one posedge passes before the next negedge
  task automatic apply(input logic a, input logic [3:0] c, input logic m, input logic [1:0] s);
    arm = a; cand_press = c; mode = m; result_sel = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(1'b0, 4'd0, 1'b0, 2'd0);
    apply(1'b0, 4'd0, 1'b0, 2'd0);
    reset = 1'b0;
  endtask

  task automatic do_vote(input logic [3:0] c);
    apply(1'b1, 4'd0, 1'b0, 2'd0);
    apply(1'b0, c, 1'b0, 2'd0);
    repeat (10) apply(1'b0, 4'd0, 1'b0, 2'd0);
  endtask

  task automatic read_cnt(input logic [1:0] s, output logic [7:0] v);
    apply(1'b0, 4'd0, 1'b1, s);
    apply(1'b0, 4'd0, 1'b1, s);
    v = result;
    apply(1'b0, 4'd0, 1'b0, s);
    apply(1'b0, 4'd0, 1'b0, s);
  endtask

  initial begin
    logic [7:0] v;
    int n_ack;

    //            arm cand     md sel ex rdy ack rej res tot
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b0, 8'd0, 10'd0};
    vecs[1]  = '{1'b0, 4'b0101, 1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b1, 8'd0, 10'd0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b0, 8'd0, 10'd0};
    vecs[3]  = '{1'b0, 4'b0100, 1'b0, 2'd0, 0, 1'b0, 1'b1, 1'b0, 8'd0, 10'd1};
    vecs[4]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 0, 1'b0, 1'b1, 1'b0, 8'd0, 10'd1};
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 7, 1'b0, 1'b1, 1'b0, 8'd0, 10'd1};
    vecs[6]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[7]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[8]  = '{1'b0, 4'b0011, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[9]  = '{1'b1, 4'b0000, 1'b1, 2'd2, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[10] = '{1'b0, 4'b0001, 1'b1, 2'd2, 0, 1'b0, 1'b0, 1'b0, 8'd1, 10'd1};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[12] = '{1'b1, 4'b0000, 1'b1, 2'd1, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[13] = '{1'b0, 4'b0000, 1'b0, 2'd2, 0, 1'b0, 1'b0, 1'b0, 8'd1, 10'd1};
    vecs[14] = '{1'b0, 4'b0000, 1'b0, 2'd2, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[15] = '{1'b1, 4'b0000, 1'b1, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[16] = '{1'b0, 4'b0000, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[17] = '{1'b1, 4'b0000, 1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[18] = '{1'b1, 4'b0000, 1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[19] = '{1'b0, 4'b0001, 1'b1, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[20] = '{1'b0, 4'b0000, 1'b1, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[21] = '{1'b0, 4'b0000, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};
    vecs[22] = '{1'b0, 4'b0000, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1};

    reset = 1'b1; arm = 1'b0; cand_press = 4'd0; mode = 1'b0; result_sel = 2'd0;
    @(negedge clk);
    do_reset();
    chk("reset_ready", ready, 0);
    chk("reset_ack", vote_ack, 0);
    chk("reset_reject", reject, 0);
    chk("reset_result", result, 0);
    chk("reset_total", total_votes, 0);

    for (int i = 0; i < 23; i++) begin
      apply(vecs[i].arm, vecs[i].cand, vecs[i].mode, vecs[i].sel);
      for (int k = 0; k < vecs[i].extra; k++) apply(1'b0, 4'd0, vecs[i].mode, vecs[i].sel);
      chk($sformatf("vec%0d_ready", i), ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_ack", i), vote_ack, vecs[i].e_ack);
      chk($sformatf("vec%0d_reject", i), reject, vecs[i].e_rej);
      chk($sformatf("vec%0d_result", i), result, vecs[i].e_res);
      chk($sformatf("vec%0d_total", i), total_votes, vecs[i].e_tot);
    end

    // single vote for candidate 1 with ack window length measured
    do_reset();
    apply(1'b1, 4'd0, 1'b0, 2'd0);
    chk("v1_ready_armed", ready, 1);
    apply(1'b0, 4'b0010, 1'b0, 2'd0);
    chk("v1_ready_drop", ready, 0);
    chk("v1_total", total_votes, 1);
    n_ack = vote_ack ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      apply(1'b0, 4'd0, 1'b0, 2'd0);
      if (!vote_ack) break;
      n_ack++;
    end
    chk("v1_ack_len", n_ack, 10);
    chk("v1_idle_ready", ready, 0);
    read_cnt(2'd1, v);
    chk("v1_count1", v, 1);

    // three votes for candidate 3, result readout and cancelled arming
    do_reset();
    repeat (3) do_vote(4'b1000);
    chk("c3_total", total_votes, 3);
    apply(1'b0, 4'd0, 1'b1, 2'd3);
    chk("c3_result_first", result, 0);
    apply(1'b0, 4'd0, 1'b1, 2'd3);
    chk("c3_result", result, 3);
    apply(1'b0, 4'd0, 1'b0, 2'd3);
    apply(1'b0, 4'd0, 1'b0, 2'd3);
    chk("c3_result_cleared", result, 0);
    apply(1'b1, 4'd0, 1'b0, 2'd0);
    chk("c3_armed", ready, 1);
    apply(1'b0, 4'b1000, 1'b1, 2'd3);
    chk("c3_cancel_ready", ready, 0);
    chk("c3_cancel_ack", vote_ack, 0);
    apply(1'b0, 4'd0, 1'b1, 2'd3);
    chk("c3_cancel_count", result, 3);
    chk("c3_cancel_total", total_votes, 3);
    apply(1'b0, 4'd0, 1'b0, 2'd3);
    apply(1'b0, 4'd0, 1'b0, 2'd3);

    // reset during the fourth ack cycle
    apply(1'b1, 4'd0, 1'b0, 2'd0);
    apply(1'b0, 4'b0100, 1'b0, 2'd0);
    repeat (3) apply(1'b0, 4'd0, 1'b0, 2'd0);
    chk("rack_ack_before", vote_ack, 1);
    reset = 1'b1;
    apply(1'b1, 4'b0100, 1'b0, 2'd0);
    reset = 1'b0;
    chk("rack_ack", vote_ack, 0);
    chk("rack_total", total_votes, 0);
    chk("rack_ready", ready, 0);
    apply(1'b0, 4'd0, 1'b0, 2'd0);
    chk("rack_no_residual", vote_ack, 0);
    read_cnt(2'd3, v);
    chk("rack_count3", v, 0);
    read_cnt(2'd2, v);
    chk("rack_count2", v, 0);

    // reset while armed: the arming must not survive
    apply(1'b1, 4'd0, 1'b0, 2'd0);
    reset = 1'b1;
    apply(1'b0, 4'd0, 1'b0, 2'd0);
    reset = 1'b0;
    chk("rarm_ready", ready, 0);
    apply(1'b0, 4'b0001, 1'b0, 2'd0);
    chk("rarm_no_vote_ack", vote_ack, 0);
    chk("rarm_no_vote_total", total_votes, 0);

    // saturation of candidate 0 after 255 votes
    do_reset();
    repeat (255) do_vote(4'b0001);
    chk("sat_total_255", total_votes, 255);
    apply(1'b1, 4'd0, 1'b0, 2'd0);
    apply(1'b0, 4'b0001, 1'b0, 2'd0);
    chk("sat_ack", vote_ack, 1);
    chk("sat_total_256", total_votes, 256);
    repeat (10) apply(1'b0, 4'd0, 1'b0, 2'd0);
    read_cnt(2'd0, v);
    chk("sat_count0", v, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
